// File: rtl/imm_pkg.sv
// Shared constants for the immediate generator: RISC-V opcodes, immediate
// format codes, skid-buffer state encoding and the stored entry width.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;
  localparam logic [2:0] IMM_Z    = 3'd6;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // Stored entry is {imm, imm_type, pc_imm, illegal}.
  function automatic int entry_width(input int xlen);
    return 2 * xlen + 3 + 1;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder: raw instruction -> immediate,
// format class and illegal flag for an RV32 or RV64 datapath.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            illegal
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_shift;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Every format is first assembled as a 32-bit value, then widened.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;

  assign imm_i32 = {{20{instr[31]}}, instr[31:20]};
  assign imm_s32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u32 = {instr[31:12], 12'b0};
  assign imm_j32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    imm      = '0;
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        imm_type = IMM_I;
        imm      = sext32(imm_i32);
      end
      OPC_OP_IMM: begin
        imm_type = IMM_I;
        if (!is_shift)  imm = sext32(imm_i32);
        else if (RV64)  imm = XLEN'(instr[25:20]);
        else            imm = XLEN'(instr[24:20]);
      end
      OPC_OP_IMM_32: begin
        // Word-sized shifts always use the 5-bit shamt.
        if (RV64) begin
          imm_type = IMM_I;
          imm      = is_shift ? XLEN'(instr[24:20]) : sext32(imm_i32);
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        imm_type = IMM_S;
        imm      = sext32(imm_s32);
      end
      OPC_BRANCH: begin
        imm_type = IMM_B;
        imm      = sext32(imm_b32);
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_type = IMM_U;
        imm      = sext32(imm_u32);
      end
      OPC_JAL: begin
        imm_type = IMM_J;
        imm      = sext32(imm_j32);
      end
      OPC_SYSTEM: begin
        if (funct3[2]) begin
          imm_type = IMM_Z;
          imm      = XLEN'(instr[19:15]);
        end
      end
      OPC_OP, OPC_MISC_MEM: ;
      OPC_OP_32: illegal = !RV64;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes on the input side and holds results
// in a registered stage, optionally backed by a skid entry for full throughput.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      imm_type_o,
  output logic [XLEN-1:0] pc_imm_o,
  output logic            illegal_o,
  output logic [1:0]      dbg_state
);

  localparam int EW = entry_width(XLEN);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // the producer holds valid and payload until it does, and the held entry
  // stays unchanged while out_valid_o && !out_ready_i.

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_type;
  logic            dec_illegal;
  logic [EW-1:0]   new_entry;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr    (instr_i),
    .imm      (dec_imm),
    .imm_type (dec_type),
    .illegal  (dec_illegal)
  );

  assign new_entry = {dec_imm, dec_type, pc_i + dec_imm, dec_illegal};

  skid_state_e   state_q, state_d;
  logic [EW-1:0] main_q, skid_q;
  logic          in_acc, out_pop;
  logic          load_main, load_skid, main_from_skid;

  // Without a skid entry, ready must see the consumer combinationally; with
  // it, ready is a decode of the state register only. FULL is unreachable
  // when SKID=0.
  assign in_ready_o  = SKID ? (state_q != ST_FULL)
                            : ((state_q == ST_EMPTY) || out_ready_i);
  assign out_valid_o = (state_q != ST_EMPTY);
  assign in_acc      = in_valid_i && in_ready_o;
  assign out_pop     = out_valid_o && out_ready_i;
  assign dbg_state   = state_q;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_acc) begin
          state_d   = ST_MAIN;
          load_main = 1'b1;
        end
      end
      ST_MAIN: begin
        case ({in_acc, out_pop})
          2'b10: begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end
          2'b01: state_d = ST_EMPTY;
          2'b11: load_main = 1'b1;
          default: ;
        endcase
      end
      ST_FULL: begin
        if (out_pop) begin
          state_d        = ST_MAIN;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main)           main_q <= new_entry;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= new_entry;
    end
  end

  assign {imm_o, imm_type_o, pc_imm_o, illegal_o} = main_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (RV32 skid, RV32 no-skid, RV64 skid)
// checked against an arithmetic reference decoder and an expected queue.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  localparam int EW = 132;  // {imm[63:0], type[2:0], pc_imm[63:0], illegal}

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [31:0] instr     [3];
  logic [63:0] pc        [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [2:0]  imm_type  [3];
  logic        illegal   [3];
  logic [1:0]  dbg_state [3];
  logic [63:0] obs_imm   [3];
  logic [63:0] obs_pcimm [3];
  logic [31:0] imm_a, imm_b, pcimm_a, pcimm_b;
  logic [63:0] imm_c, pcimm_c;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SKID(1'b1)) u_s1 (
    .clk(clk), .reset(reset), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .instr_i(instr[0]), .pc_i(pc[0][31:0]), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready[0]), .imm_o(imm_a), .imm_type_o(imm_type[0]),
    .pc_imm_o(pcimm_a), .illegal_o(illegal[0]), .dbg_state(dbg_state[0]));

  imm_gen_pipe #(.XLEN(32), .SKID(1'b0)) u_s0 (
    .clk(clk), .reset(reset), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .instr_i(instr[1]), .pc_i(pc[1][31:0]), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready[1]), .imm_o(imm_b), .imm_type_o(imm_type[1]),
    .pc_imm_o(pcimm_b), .illegal_o(illegal[1]), .dbg_state(dbg_state[1]));

  imm_gen_pipe #(.XLEN(64), .SKID(1'b1)) u_x64 (
    .clk(clk), .reset(reset), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .instr_i(instr[2]), .pc_i(pc[2]), .out_valid_o(out_valid[2]),
    .out_ready_i(out_ready[2]), .imm_o(imm_c), .imm_type_o(imm_type[2]),
    .pc_imm_o(pcimm_c), .illegal_o(illegal[2]), .dbg_state(dbg_state[2]));

  assign obs_imm[0]   = {32'b0, imm_a};
  assign obs_imm[1]   = {32'b0, imm_b};
  assign obs_imm[2]   = imm_c;
  assign obs_pcimm[0] = {32'b0, pcimm_a};
  assign obs_pcimm[1] = {32'b0, pcimm_b};
  assign obs_pcimm[2] = pcimm_c;

  function automatic logic [EW-1:0] obs_entry(input int d);
    return {obs_imm[d], imm_type[d], obs_pcimm[d], illegal[d]};
  endfunction

  // Reference decoder built from field arithmetic on a sign-extended word.
  function automatic logic [EW-1:0] model(input logic [31:0] ins, input logic [63:0] pcv,
                                          input bit rv64);
    longint sx, sgn, hi, f_a, f_b, f_c, f_d, imm;
    logic [63:0] immu, pci;
    logic [2:0]  ty;
    bit          ill, shift;
    sx    = longint'($signed(ins));
    sgn   = sx >>> 31;
    imm   = 0;
    ty    = 3'd0;
    ill   = 1'b0;
    shift = (ins[14:12] == 3'd1) || (ins[14:12] == 3'd5);
    case (ins[6:0])
      7'h03, 7'h67: begin ty = 3'd1; imm = sx >>> 20; end
      7'h13: begin
        ty = 3'd1;
        if (!shift) imm = sx >>> 20;
        else begin f_a = (ins >> 20) & (rv64 ? 63 : 31); imm = f_a; end
      end
      7'h1B: begin
        if (rv64) begin
          ty = 3'd1;
          if (!shift) imm = sx >>> 20;
          else begin f_a = (ins >> 20) & 31; imm = f_a; end
        end else ill = 1'b1;
      end
      7'h23: begin ty = 3'd2; hi = sx >>> 25; f_a = (ins >> 7) & 31; imm = hi * 32 + f_a; end
      7'h63: begin
        ty = 3'd3;
        f_a = (ins >> 7) & 1; f_b = (ins >> 25) & 63; f_c = (ins >> 8) & 15;
        imm = sgn * 4096 + f_a * 2048 + f_b * 32 + f_c * 2;
      end
      7'h37, 7'h17: begin ty = 3'd4; hi = sx >>> 12; imm = hi * 4096; end
      7'h6F: begin
        ty = 3'd5;
        f_a = (ins >> 12) & 255; f_b = (ins >> 20) & 1; f_c = (ins >> 21) & 1023;
        f_d = 1048576;
        imm = sgn * f_d + f_a * 4096 + f_b * 2048 + f_c * 2;
      end
      7'h73: if (ins[14]) begin ty = 3'd6; f_a = (ins >> 15) & 31; imm = f_a; end
      7'h33, 7'h0F: ;
      7'h3B: ill = !rv64;
      default: ill = 1'b1;
    endcase
    immu = imm;
    pci  = pcv + immu;
    if (!rv64) begin
      immu = immu & 64'hFFFF_FFFF;
      pci  = pci & 64'hFFFF_FFFF;
    end
    return {immu, ty, pci, ill};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [14];
    logic [31:0] r;
    int          k;
    opcs = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37,
             7'h17, 7'h6F, 7'h73, 7'h33, 7'h3B, 7'h0F, 7'h13};
    r = $urandom();
    k = $urandom_range(0, 15);
    if (k >= 14) return r;
    return {r[31:7], opcs[k]};
  endfunction

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; instr[d] = '0; pc[d] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if ({out_valid[d], in_ready[d], obs_entry(d)} !== {1'b0, 1'b1, {EW{1'b0}}}) begin
        $display("FAIL reset dut%0d: valid=%0b ready=%0b entry=%h, want valid=0 ready=1 entry=0",
                 d, out_valid[d], in_ready[d], obs_entry(d));
      end else n_pass++;
    end
  endtask

  typedef struct {
    int          d;
    logic [31:0] ins;
    logic [63:0] pcv;
    logic [63:0] imm;
    logic [2:0]  ty;
    logic [63:0] pcimm;
    logic        ill;
  } vec_t;

  task automatic test_directed();
    vec_t v[$];
    v.push_back('{0, 32'hFFF00093, 64'h0,    64'hFFFFFFFF, 3'd1, 64'hFFFFFFFF, 1'b0});
    v.push_back('{0, 32'h8000006F, 64'h1000, 64'hFFF00000, 3'd5, 64'hFFF01000, 1'b0});
    v.push_back('{0, 32'hFE000EE3, 64'h2000, 64'hFFFFFFFC, 3'd3, 64'h00001FFC, 1'b0});
    v.push_back('{0, 32'h00000000, 64'h3000, 64'h0,        3'd0, 64'h3000,     1'b1});
    v.push_back('{0, 32'h03F09093, 64'h0,    64'd31,       3'd1, 64'd31,       1'b0});
    v.push_back('{0, 32'h0000001B, 64'h0,    64'h0,        3'd0, 64'h0,        1'b1});
    v.push_back('{0, 32'h000FD073, 64'h100,  64'd31,       3'd6, 64'h11F,      1'b0});
    v.push_back('{0, 32'hFE112E23, 64'h40,   64'hFFFFFFFC, 3'd2, 64'h3C,       1'b0});
    v.push_back('{2, 32'h800000B7, 64'h0,    64'hFFFFFFFF80000000, 3'd4, 64'hFFFFFFFF80000000, 1'b0});
    v.push_back('{2, 32'h03F09093, 64'h10,   64'd63,       3'd1, 64'h4F,       1'b0});
    v.push_back('{2, 32'hFFF0009B, 64'h0,    64'hFFFFFFFFFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0});
    foreach (v[i]) begin
      @(posedge clk); #1;
      in_valid[v[i].d] = 1'b1; instr[v[i].d] = v[i].ins; pc[v[i].d] = v[i].pcv;
      out_ready[v[i].d] = 1'b1;
      @(posedge clk); #1;
      in_valid[v[i].d] = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({out_valid[v[i].d], obs_entry(v[i].d)} !==
          {1'b1, v[i].imm, v[i].ty, v[i].pcimm, v[i].ill}) begin
        $display("FAIL directed instr=%h: valid=%0b imm=%h type=%0d pc_imm=%h ill=%0b, want imm=%h type=%0d pc_imm=%h ill=%0b",
                 v[i].ins, out_valid[v[i].d], obs_imm[v[i].d], imm_type[v[i].d],
                 obs_pcimm[v[i].d], illegal[v[i].d], v[i].imm, v[i].ty, v[i].pcimm, v[i].ill);
      end else n_pass++;
      @(posedge clk); #1;
      out_ready[v[i].d] = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    // SKID=0 instance: continuous valid and ready, one entry per cycle.
    @(posedge clk); #1;
    out_ready[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid[1] = 1'b1; instr[1] = {12'(i + 1), 20'h00013}; pc[1] = 64'h0;
      @(negedge clk);
      n_checks++;
      if (in_ready[1] !== 1'b1) begin
        $display("FAIL b2b_ready step %0d: in_ready=%0b, want 1", i, in_ready[1]);
      end else n_pass++;
      if (i > 0) begin
        n_checks++;
        if ({out_valid[1], obs_imm[1]} !== {1'b1, 64'(i)}) begin
          $display("FAIL b2b_data step %0d: valid=%0b imm=%h, want valid=1 imm=%0d",
                   i, out_valid[1], obs_imm[1], i);
        end else n_pass++;
      end
      @(posedge clk); #1;
    end
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] ins [3];
    int          popped;
    bit          acc, pop;
    ins = '{32'h00100013, 32'h00200013, 32'h00300013};
    exp_q.delete();
    @(posedge clk); #1;
    out_ready[0] = 1'b0; pc[0] = 64'h0;
    for (int i = 0; i < 3; i++) begin
      in_valid[0] = 1'b1; instr[0] = ins[i];
      exp_q.push_back(model(ins[i], 64'h0, 1'b0));
      if (i < 2) begin @(posedge clk); #1; end
    end
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({in_ready[0], dbg_state[0], obs_entry(0)} !== {1'b0, ST_FULL, exp_q[0]}) begin
        $display("FAIL backpressure_hold: in_ready=%0b state=%0d imm=%h, want in_ready=0 state=2 imm=1",
                 in_ready[0], dbg_state[0], obs_imm[0]);
      end else n_pass++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    popped = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      acc = in_valid[0] && in_ready[0];
      pop = out_valid[0] && out_ready[0];
      if (pop) begin
        popped++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL backpressure_order: extra entry imm=%h, want none", obs_imm[0]);
        end else if (obs_entry(0) !== exp_q[0]) begin
          $display("FAIL backpressure_order: imm=%h, want %h", obs_imm[0], exp_q[0][131:68]);
        end else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      @(posedge clk); #1;
      if (acc) in_valid[0] = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if ({popped, out_valid[0]} !== {32'd3, 1'b0}) begin
      $display("FAIL backpressure_count: popped=%0d valid=%0b, want popped=3 valid=0",
               popped, out_valid[0]);
    end else n_pass++;
    out_ready[0] = 1'b0;
  endtask

  task automatic test_random(input int d, input int n_items);
    int sent = 0, got = 0, cyc = 0;
    bit acc, pop;
    exp_q.delete();
    @(posedge clk); #1;
    in_valid[d] = 1'b0; out_ready[d] = 1'b0;
    while ((sent < n_items || got < sent) && cyc < 3000) begin
      @(negedge clk);
      if (out_valid[d]) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL random dut%0d: unexpected entry %h, want none", d, obs_entry(d));
        end else if (obs_entry(d) !== exp_q[0]) begin
          $display("FAIL random dut%0d: entry %h, want %h", d, obs_entry(d), exp_q[0]);
        end else n_pass++;
      end
      acc = in_valid[d] && in_ready[d];
      pop = out_valid[d] && out_ready[d];
      @(posedge clk); #1;
      if (pop && exp_q.size() != 0) begin void'(exp_q.pop_front()); got++; end
      if (acc) begin exp_q.push_back(model(instr[d], pc[d], d == 2)); sent++; end
      if (!in_valid[d] || acc) begin
        if (sent < n_items && $urandom_range(0, 9) < 7) begin
          in_valid[d] = 1'b1;
          instr[d]    = rand_instr();
          pc[d]       = (d == 2) ? {$urandom(), $urandom()} : {32'b0, $urandom()};
        end else in_valid[d] = 1'b0;
      end
      out_ready[d] = ($urandom_range(0, 9) < 6);
      cyc++;
    end
    in_valid[d] = 1'b0; out_ready[d] = 1'b0;
    n_checks++;
    if (cyc >= 3000 || exp_q.size() != 0 || got != n_items) begin
      $display("FAIL random_drain dut%0d: got=%0d left=%0d cycles=%0d, want got=%0d left=0",
               d, got, exp_q.size(), cyc, n_items);
    end else n_pass++;
  endtask

  task automatic test_reset_async();
    @(posedge clk); #1;
    out_ready[0] = 1'b0; in_valid[0] = 1'b1; instr[0] = 32'hFFF00093; pc[0] = 64'h500;
    @(posedge clk); #1;
    instr[0] = 32'h8000006F;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dbg_state[0] !== ST_FULL) begin
      $display("FAIL async_reset_setup: state=%0d, want 2", dbg_state[0]);
    end else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({out_valid[0], in_ready[0], dbg_state[0], obs_entry(0)} !==
        {1'b0, 1'b1, ST_EMPTY, {EW{1'b0}}}) begin
      $display("FAIL async_reset: valid=%0b ready=%0b state=%0d entry=%h, want 0 1 0 0",
               out_valid[0], in_ready[0], dbg_state[0], obs_entry(0));
    end else n_pass++;
    @(posedge clk); #1 reset = 1'b0;
    // Fresh transaction after reset behaves as from power-up.
    in_valid[0] = 1'b1; instr[0] = 32'hFE000EE3; pc[0] = 64'h2000; out_ready[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid[0], obs_entry(0)} !== {1'b1, 64'hFFFFFFFC, 3'd3, 64'h1FFC, 1'b0}) begin
      $display("FAIL post_reset: valid=%0b imm=%h pc_imm=%h, want valid=1 imm=fffffffc pc_imm=1ffc",
               out_valid[0], obs_imm[0], obs_pcimm[0]);
    end else n_pass++;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
  endtask

  initial begin
    idle_all();
    do_reset();
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random(0, 150);
    test_random(1, 150);
    test_random(2, 150);
    test_reset_async();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the RISC-V core. It decodes the immediate, its format class and a PC-relative target from a raw 32-bit instruction. Results sit in a registered valid/ready stage, with an optional skid buffer for full throughput under backpressure. It sits between instruction fetch and the decode/execute boundary.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SKID, 1, 1 = two-entry skid buffer (registered ready); 0 = single register stage.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  upstream instruction valid.
- in_ready_o  out  1  block can accept an instruction this cycle.
- instr_i  in  32  raw instruction word.
- pc_i  in  XLEN  PC of instr_i.
- out_valid_o  out  1  output entry valid.
- out_ready_i  in  1  downstream accepts the output entry.
- imm_o  out  XLEN  decoded immediate.
- imm_type_o  out  3  format class: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
- pc_imm_o  out  XLEN  pc_i + imm_o modulo 2^XLEN.
- illegal_o  out  1  unrecognised opcode, or instr_i[1:0] != 2'b11.

## Operation
- Decode by opcode instr_i[6:0]:
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111 -> I: sign-extend instr[31:20].
  - OP-IMM with funct3 001/101 -> I. Immediate is the zero-extended shamt: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - OP-IMM-32 0011011 -> I, accepted only when XLEN=64. Shift forms use the 5-bit shamt. With XLEN=32 it is NONE plus illegal.
  - STORE 0100011 -> S: sign-extend {instr[31:25], instr[11:7]}.
  - BRANCH 1100011 -> B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - LUI 0110111, AUIPC 0010111 -> U: {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
  - JAL 1101111 -> J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}. The sign source is bit 31.
  - SYSTEM 1110011 with funct3[2]=1 -> Z: zero-extend instr[19:15]. Other SYSTEM funct3 -> NONE, imm 0.
  - OP 0110011, OP-32 0111011 (XLEN=64 only), MISC-MEM 0001111 -> NONE, imm 0, legal.
  - Any other opcode -> NONE, imm 0, illegal_o=1.
- pc_imm_o is always computed and wraps silently. It is meaningful for B, J and AUIPC.
- Decode happens on the input side. Entries store {imm, type, pc_imm, illegal}, so every output is driven straight from a register.

## Timing
- Reset: out_valid_o=0, imm_o=0, imm_type_o=0, pc_imm_o=0, illegal_o=0. in_ready_o=1 for SKID=1; for SKID=0 it follows its combinational rule.
- Transfer rule: an input transfer occurs when in_valid_i && in_ready_o at the edge. An output transfer occurs when out_valid_o && out_ready_i.
- Latency: 1 cycle from input acceptance to out_valid_o, when the stage is empty.
- SKID=1, states EMPTY, MAIN, FULL. in_ready_o = (state != FULL), registered, with no combinational path from out_ready_i.
  - EMPTY: accept -> MAIN.
  - MAIN: accept without pop -> FULL (new entry into skid). Pop without accept -> EMPTY. Accept and pop together -> MAIN, main reg loaded with the new entry.
  - FULL: pop -> MAIN, skid moves to main, in_ready_o rises on the same edge. No accept is possible in FULL.
- SKID=0: in_ready_o = !out_valid_o || out_ready_i, combinational. Simultaneous accept and pop replaces the entry, giving throughput of 1 per cycle.
- Ordering: strict FIFO order, no drop, no duplication.
- Output stability: entry contents stay stable while out_valid_o && !out_ready_i.
- Reset mid-operation: assertion immediately empties the stage and zeroes outputs, and in-flight entries are discarded. After deassertion the block behaves as from power-up.

## Structure
- Package imm_pkg holds the opcode constants, the imm_type codes (3-bit localparams) and the entry struct width helper.
- Sub-module imm_decode is purely combinational: instr + XLEN parameter -> imm, type, illegal.
- The top level holds the adder, the skid buffer registers and the state.

## Test plan
- XLEN=32, instr 0xFFF00093 (addi x1,x0,-1), pc 0x0 -> one cycle later imm_o=0xFFFFFFFF, type 1, pc_imm_o=0xFFFFFFFF, illegal 0.
- instr 0x8000006F (JAL, imm bit 20 set), pc 0x1000 -> imm_o=0xFFF00000, type 5, pc_imm_o=0xFFF01000.
- instr 0xFE000EE3 (BEQ -4), pc 0x2000 -> imm_o=0xFFFFFFFC, type 3, pc_imm_o=0x00001FFC. Follow with instr 0x00000000 -> illegal_o=1, type 0, imm 0.
- SKID=1 backpressure: out_ready_i=0, offer A, B, C back-to-back -> A and B accepted, in_ready_o=0 while C is held. Raise out_ready_i -> A, B, C emerge in order on consecutive cycles, with no duplicate.
- XLEN=64: LUI 0x800000B7 -> imm_o=0xFFFFFFFF80000000. slli 0x03F09093 -> imm_o=63, type 1. Same slli with XLEN=32 -> imm_o=31.
- Assert reset asynchronously while in FULL -> out_valid_o=0, in_ready_o=1 and all outputs 0 before the next clock edge.
